// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready write channel feeding the UART transmit FIFO.
//   tx_valid  producer -> FIFO  word offered on this clock
//   tx_data   producer -> FIFO  DATA_BITS-wide word, LSB goes on the line first
//   tx_ready  FIFO -> producer  FIFO has room; a word moves when valid && ready
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  modport master (output tx_valid, tx_data, input tx_ready);
  modport slave (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with TX FIFO, CTS flow control
// and gap-free back-to-back framing.
//   sys_clk     system clock
//   sys_rst_n   asynchronous active-low reset
//   wr          write channel (slave side): tx_valid, tx_data, tx_ready
//   cts_n       peer clear-to-send, active-low, asynchronous to sys_clk
//   fifo_level  words waiting in the FIFO (the frame on the wire is not counted)
//   tx_busy     a frame is on the wire
//   tx_done     one-clock pulse on the last clock of the final stop bit
//   uart_txd    serial line, idle high
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  uart_tx_fifo_if.slave               wr,
  input  logic                        cts_n,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        uart_txd
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BPS_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(BPS_CNT - 2);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BPS_CNT < 4) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ/UART_BPS must be >= 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          lvl_q, lvl_d;
  logic [1:0]           cts_q, cts_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 rdy, push, pop, load, go, last;
  logic [DATA_BITS-1:0] head;

  always_comb begin
    rdy     = lvl_q != (AW+1)'(FIFO_DEPTH);
    push    = wr.tx_valid && rdy;
    go      = lvl_q != '0 && !cts_q[1];
    last    = cnt_q == CNT_LAST;
    head    = mem_q[rd_q];
    load    = 1'b0;
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    txd_d   = txd_q;
    cts_d   = {cts_q[0], cts_n};
    cnt_d   = (state_q == S_IDLE || last) ? '0 : cnt_q + CW'(1);
    // registered pulse: raised one clock early so it lines up with the final stop clock
    done_d  = state_q == S_STOP && bit_q == 3'(STOP_BITS - 1) && cnt_q == CNT_DONE;
    case (state_q)
      S_IDLE: load = go;
      S_START: if (last) begin
        state_d = S_DATA;
        bit_d   = '0;
        txd_d   = sh_q[0];
      end
      S_DATA: if (last) begin
        if (bit_q == 3'(DATA_BITS - 1)) begin
          state_d = PARITY != 0 ? S_PAR : S_STOP;
          txd_d   = PARITY != 0 ? par_q : 1'b1;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = sh_q >> 1;
          txd_d = sh_q[1];
        end
      end
      S_PAR: if (last) begin
        state_d = S_STOP;
        bit_d   = '0;
        txd_d   = 1'b1;
      end
      S_STOP: if (last) begin
        if (bit_q == 3'(STOP_BITS - 1)) begin
          load    = go;
          state_d = S_IDLE;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: ;
    endcase
    // frame start, shared by IDLE and the end of a stop period so frames abut
    pop = load;
    if (load) begin
      state_d = S_START;
      sh_d    = head;
      par_d   = (^head) ^ (PARITY == 1);
      txd_d   = 1'b0;
      cnt_d   = '0;
    end
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    lvl_d = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      cts_q   <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      cts_q   <= cts_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_q] <= wr.tx_data;
  end

  assign wr.tx_ready = rdy;
  assign fifo_level  = lvl_q;
  assign tx_busy     = state_q != S_IDLE;
  assign tx_done     = done_q;
  assign uart_txd    = txd_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench over four frame formats (8N1/depth 4, 7E1, 7O1, 8N2).
module tb_uart_tx_fifo;
  logic sys_clk = 1'b0;
  logic sys_rst_n, cts_n;
  always #5 sys_clk = ~sys_clk;

  logic       vld [4];
  logic [7:0] din;
  logic       txd [4], done [4], busy [4], rdy [4];
  logic [4:0] lvl [4];
  logic [2:0] lvl0;
  logic [1:0] sel;
  logic       txd_m, done_m, busy_m, rdy_m;
  logic [4:0] lvl_m;
  logic [7:0] exp_q [$];
  int n_chk = 0, n_fail = 0;

  uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign if3.tx_valid = vld[3];
  assign if0.tx_data = din;
  assign if1.tx_data = din[6:0];
  assign if2.tx_data = din[6:0];
  assign if3.tx_data = din;
  assign rdy[0] = if0.tx_ready;
  assign rdy[1] = if1.tx_ready;
  assign rdy[2] = if2.tx_ready;
  assign rdy[3] = if3.tx_ready;
  assign lvl[0] = {2'b00, lvl0};

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr(if0), .cts_n(cts_n),
    .fifo_level(lvl0), .tx_busy(busy[0]), .tx_done(done[0]), .uart_txd(txd[0]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr(if1), .cts_n(cts_n),
    .fifo_level(lvl[1]), .tx_busy(busy[1]), .tx_done(done[1]), .uart_txd(txd[1]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr(if2), .cts_n(cts_n),
    .fifo_level(lvl[2]), .tx_busy(busy[2]), .tx_done(done[2]), .uart_txd(txd[2]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr(if3), .cts_n(cts_n),
    .fifo_level(lvl[3]), .tx_busy(busy[3]), .tx_done(done[3]), .uart_txd(txd[3]));

  always_comb begin
    txd_m  = txd[sel];
    done_m = done[sel];
    busy_m = busy[sel];
    rdy_m  = rdy[sel];
    lvl_m  = lvl[sel];
  end

  task automatic push(input logic [7:0] w, output logic acc);
    @(negedge sys_clk);
    din = w;
    vld[sel] = 1'b1;
    acc = rdy_m;
    @(posedge sys_clk);
    #1 vld[sel] = 1'b0;
    if (acc) exp_q.push_back(w);
  endtask

  // Waits for a start bit, then checks every clock of the frame against a waveform built from the scoreboard word.
  task automatic rx_frame(output int wt);
    int nb, pm, ns, len, bad_k, bad_d, bad_b;
    logic [7:0] d;
    logic [11:0] fr;
    logic bw, bwe, bd;
    nb = (sel == 1 || sel == 2) ? 7 : 8;
    pm = sel == 1 ? 2 : sel == 2 ? 1 : 0;
    ns = sel == 3 ? 2 : 1;
    len = (1 + nb + (pm != 0 ? 1 : 0) + ns) * 10;
    wt = 0;
    do begin
      @(negedge sys_clk);
      wt++;
    end while (txd_m !== 1'b0 && wt < 300);
    n_chk++;
    if (txd_m !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_start sel=%0d: uart_txd=%b after %0d clks, expected start bit 0", sel, txd_m, wt);
      return;
    end
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL rx_unexpected sel=%0d: frame started with empty scoreboard, expected no frame", sel);
      return;
    end
    d = exp_q.pop_front();
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < nb; i++) fr[1+i] = d[i];
    if (pm != 0) fr[1+nb] = (^(d & (8'hFF >> (8 - nb)))) ^ (pm == 1);
    bad_k = -1; bad_d = -1; bad_b = -1; bw = 0; bwe = 0; bd = 0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge sys_clk);
      if (bad_k < 0 && txd_m !== fr[k/10]) begin bad_k = k; bw = txd_m; bwe = fr[k/10]; end
      if (bad_d < 0 && done_m !== (k == len - 1)) begin bad_d = k; bd = done_m; end
      if (bad_b < 0 && busy_m !== 1'b1) bad_b = k;
    end
    n_chk++;
    if (bad_k >= 0) begin
      n_fail++;
      $display("FAIL frame_bits sel=%0d word=%h: clk %0d uart_txd=%b expected %b", sel, d, bad_k, bw, bwe);
    end
    n_chk++;
    if (bad_d >= 0) begin
      n_fail++;
      $display("FAIL tx_done sel=%0d word=%h: clk %0d tx_done=%b expected %b", sel, d, bad_d, bd, !bd);
    end
    n_chk++;
    if (bad_b >= 0) begin
      n_fail++;
      $display("FAIL tx_busy sel=%0d word=%h: clk %0d tx_busy low, expected 1", sel, d, bad_b);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      n_chk += 5;
      if (txd_m !== 1'b1) begin n_fail++; $display("FAIL reset_txd sel=%0d: got %b expected 1", sel, txd_m); end
      if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL reset_ready sel=%0d: got %b expected 1", sel, rdy_m); end
      if (lvl_m !== 5'd0) begin n_fail++; $display("FAIL reset_level sel=%0d: got %0d expected 0", sel, lvl_m); end
      if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy sel=%0d: got %b expected 0", sel, busy_m); end
      if (done_m !== 1'b0) begin n_fail++; $display("FAIL reset_done sel=%0d: got %b expected 0", sel, done_m); end
    end
  endtask

  task automatic test_8n1;
    logic acc;
    int wt;
    sel = 2'd0;
    push(8'h55, acc);
    n_chk++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL 8n1_accept: tx_ready=%b expected 1", acc); end
    rx_frame(wt);
    n_chk++;
    if (wt != 2) begin n_fail++; $display("FAIL 8n1_latency: start seen at negedge %0d expected 2", wt); end
    @(negedge sys_clk);
    n_chk++;
    if (busy_m !== 1'b0 || txd_m !== 1'b1) begin
      n_fail++;
      $display("FAIL 8n1_idle_after: busy=%b txd=%b expected 0 1", busy_m, txd_m);
    end
  endtask

  task automatic test_parity;
    logic acc;
    int wt;
    sel = 2'd1;
    push(8'h07, acc);
    push(8'h2C, acc);
    rx_frame(wt);
    rx_frame(wt);
    sel = 2'd2;
    push(8'h07, acc);
    rx_frame(wt);
    n_chk++;
    if (wt != 2) begin n_fail++; $display("FAIL 7o1_latency: start seen at negedge %0d expected 2", wt); end
  endtask

  task automatic test_back_to_back;
    logic acc;
    int wt;
    sel = 2'd3;
    push(8'hA3, acc);
    push(8'h0F, acc);
    rx_frame(wt);
    rx_frame(wt);
    n_chk++;
    if (wt != 1) begin n_fail++; $display("FAIL b2b_gap: second start after %0d clks expected 1", wt); end
  endtask

  task automatic test_fifo_full;
    logic acc;
    int wt;
    sel = 2'd0;
    cts_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i), acc);
      n_chk += 2;
      if (acc !== (i < 4)) begin n_fail++; $display("FAIL full_ready push %0d: tx_ready=%b expected %b", i, acc, i < 4); end
      if (lvl_m !== 5'(i < 4 ? i + 1 : 4)) begin
        n_fail++;
        $display("FAIL full_level push %0d: fifo_level=%0d expected %0d", i, lvl_m, i < 4 ? i + 1 : 4);
      end
    end
    @(negedge sys_clk);
    n_chk++;
    if (txd_m !== 1'b1 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL full_blocked: txd=%b busy=%b expected 1 0", txd_m, busy_m);
    end
    cts_n = 1'b0;
    rx_frame(wt);
    n_chk++;
    if (wt != 3) begin n_fail++; $display("FAIL cts_latency: start after %0d clks expected 3", wt); end
    for (int i = 0; i < 3; i++) begin
      rx_frame(wt);
      n_chk++;
      if (wt != 1) begin n_fail++; $display("FAIL full_gap frame %0d: start after %0d clks expected 1", i + 1, wt); end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: %0d words unsent expected 0", exp_q.size()); end
  endtask

  task automatic test_cts_pause;
    logic acc;
    int wt;
    sel = 2'd0;
    push(8'h81, acc);
    push(8'h7E, acc);
    fork
      rx_frame(wt);
      begin
        repeat (40) @(negedge sys_clk);
        cts_n = 1'b1;
      end
    join
    repeat (5) @(negedge sys_clk);
    n_chk += 3;
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL cts_pause_busy: got %b expected 0", busy_m); end
    if (txd_m !== 1'b1) begin n_fail++; $display("FAIL cts_pause_txd: got %b expected 1", txd_m); end
    if (lvl_m !== 5'd1) begin n_fail++; $display("FAIL cts_pause_level: got %0d expected 1", lvl_m); end
    cts_n = 1'b0;
    rx_frame(wt);
    n_chk++;
    if (wt != 3) begin n_fail++; $display("FAIL cts_resume: start after %0d clks expected 3", wt); end
  endtask

  task automatic test_reset_mid;
    logic acc;
    int wt, bad;
    sel = 2'd0;
    push(8'hF0, acc);
    push(8'h11, acc);
    push(8'h22, acc);
    push(8'h33, acc);
    repeat (42) @(negedge sys_clk);
    n_chk++;
    if (txd_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3: uart_txd=%b expected 0", txd_m); end
    sys_rst_n = 1'b0;
    #1;
    n_chk += 5;
    if (txd_m !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd: got %b expected 1", txd_m); end
    if (lvl_m !== 5'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d expected 0", lvl_m); end
    if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", rdy_m); end
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy_m); end
    if (done_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done_m); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (txd_m !== 1'b1 || done_m !== 1'b0 || busy_m !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL rstmid_idle: %0d non-idle clks after release, expected 0", bad); end
    push(8'h3C, acc);
    rx_frame(wt);
    n_chk++;
    if (wt != 2) begin n_fail++; $display("FAIL rstmid_restart: start at negedge %0d expected 2", wt); end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cts_n = 1'b1;
    sel = 2'd0;
    din = '0;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    repeat (2) @(negedge sys_clk);
    test_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cts_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    test_8n1();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_cts_pause();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
